// File: rtl/opb_snap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opb_snap_pkg
// Description : Shared constants and types for the simulink-to-PPC snap register
// Revision    : 1.0
// ============================================================================
package opb_snap_pkg;

  // Word indices inside the 256-byte window
  localparam logic [5:0] OFF_DATA   = 6'd0;
  localparam logic [5:0] OFF_STATUS = 6'd1;
  localparam logic [5:0] OFF_CTRL   = 6'd2;

  localparam int OVR_W = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    ACK  = ST_ACK
  } bus_state_e;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snap_capture.sv
`default_nettype none
// ============================================================================
// Module      : snap_capture
// Description : Holds captured word, fresh flag, overrun count and freeze bit
// Revision    : 1.0
// ============================================================================
module snap_capture
  import opb_snap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [31:0]      capture_data,
  input  logic             rd_data_clr,
  input  logic             ovr_clr,
  input  logic             freeze_wr,
  input  logic             freeze_val,
  output logic [31:0]      data,
  output logic             fresh,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic             freeze
);

  logic take;
  assign take = capture & ~freeze;

  // A capture beats a same-cycle DATA read; a count clear beats an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data    <= '0;
      fresh   <= 1'b0;
      ovr_cnt <= '0;
      freeze  <= 1'b0;
    end else begin
      if (take) begin
        data <= capture_data;
      end

      if (take) begin
        fresh <= 1'b1;
      end else if (rd_data_clr) begin
        fresh <= 1'b0;
      end

      if (ovr_clr) begin
        ovr_cnt <= '0;
      end else if (take && fresh && !rd_data_clr) begin
        ovr_cnt <= sat_inc(ovr_cnt);
      end

      if (freeze_wr) begin
        freeze <= freeze_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/opb_register_simulink2ppc_snap.sv
`default_nettype none
// ============================================================================
// Module      : opb_register_simulink2ppc_snap
// Description : OPB slave exposing a user-captured word, status and freeze control
// Revision    : 1.0
// ============================================================================
module opb_register_simulink2ppc_snap
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01029000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010290FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid,
  output logic                    user_frozen
);

  localparam int unused_family_w = $bits(C_FAMILY);

  bus_state_e      state;
  logic            ack_q;
  logic [31:0]     dbus_q;
  logic [31:0]     addr;
  logic [5:0]      offset;
  logic            hit;
  logic            decode;
  logic            rd;
  logic            wr;
  logic [31:0]     rdata;

  logic [31:0]     cap_data;
  logic            cap_fresh;
  logic [OVR_W-1:0] cap_ovr;
  logic            cap_freeze;

  logic            unused_inputs;
  assign unused_inputs = ^{OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-2]};

  assign addr   = OPB_ABus;
  assign offset = OPB_ABus[24:29];
  assign hit    = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // Select is only honoured in IDLE, so a held select cannot double-ack.
  assign decode = (state == IDLE) && OPB_select && hit;
  assign rd     = decode & OPB_RNW;
  assign wr     = decode & ~OPB_RNW;

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_DATA:   rdata = cap_data;
      OFF_STATUS: rdata = {cap_ovr, 15'd0, cap_fresh};
      OFF_CTRL:   rdata = {31'd0, cap_freeze};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      state  <= IDLE;
      ack_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (decode) begin
            state  <= ACK;
            ack_q  <= 1'b1;
            dbus_q <= OPB_RNW ? rdata : 32'd0;
          end
        end
        default: begin
          state  <= IDLE;
          ack_q  <= 1'b0;
          dbus_q <= '0;
        end
      endcase
    end
  end

  snap_capture u_capture (
    .clk          (OPB_Clk),
    .rst_n        (OPB_Rst),
    .capture      (user_valid),
    .capture_data (user_data_in),
    .rd_data_clr  (rd && (offset == OFF_DATA)),
    .ovr_clr      (wr && (offset == OFF_STATUS) && (|OPB_BE)),
    .freeze_wr    (wr && (offset == OFF_CTRL) && OPB_BE[3]),
    .freeze_val   (OPB_DBus[C_OPB_DWIDTH-1]),
    .data         (cap_data),
    .fresh        (cap_fresh),
    .ovr_cnt      (cap_ovr),
    .freeze       (cap_freeze)
  );

  assign Sl_DBus     = dbus_q;
  assign Sl_xferAck  = ack_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_frozen = cap_freeze;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc_snap.sv
`default_nettype none
// ============================================================================
// Module      : tb_opb_register_simulink2ppc_snap
// Description : Directed and randomized bench against a register-map reference model
// Revision    : 1.0
// ============================================================================
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h01029000;
  localparam logic [31:0] HIGH = 32'h010290FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] wdata = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout;
  logic [31:0] din = '0;
  logic        valid = 1'b0;
  logic        frozen;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_data = '0;
  bit          m_fresh = 0;
  int          m_ovr = 0;
  bit          m_freeze = 0;
  bit          m_in_ack = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk     (clk),
    .OPB_Rst     (rst_n),
    .OPB_ABus    (abus),
    .OPB_BE      (be),
    .OPB_DBus    (wdata),
    .OPB_RNW     (rnw),
    .OPB_select  (sel),
    .OPB_seqAddr (seq),
    .Sl_DBus     (sl_dbus),
    .Sl_xferAck  (sl_ack),
    .Sl_errAck   (sl_err),
    .Sl_retry    (sl_retry),
    .Sl_toutSup  (sl_tout),
    .user_data_in(din),
    .user_valid  (valid),
    .user_frozen (frozen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_reg(input int idx);
    case (idx)
      0:       return m_data;
      1:       return {m_ovr[15:0], 15'd0, m_fresh};
      2:       return {31'd0, m_freeze};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: update the model from the inputs held across the edge, then compare.
  task automatic step();
    bit hit, rd_clr, ovr_clr, cap, exp_ack;
    int idx;
    logic [31:0] exp_d;
    @(posedge clk);
    hit     = sel && (abus >= BASE) && (abus <= HIGH) && !m_in_ack;
    idx     = int'((abus >> 2) & 32'h3F);
    rd_clr  = hit && rnw && idx == 0;
    ovr_clr = hit && !rnw && idx == 1 && be != 4'b0000;
    cap     = valid && !m_freeze;
    exp_ack = hit;
    exp_d   = (hit && rnw) ? model_reg(idx) : 32'd0;
    if (!rst_n) begin
      m_data = '0; m_fresh = 0; m_ovr = 0; m_freeze = 0;
      exp_ack = 0; exp_d = '0;
    end else begin
      if (cap && m_fresh && !rd_clr && m_ovr < 65535) m_ovr++;
      if (cap) m_data = din;
      if (cap) m_fresh = 1;
      else if (rd_clr) m_fresh = 0;
      if (ovr_clr) m_ovr = 0;
      if (hit && !rnw && idx == 2 && be[3]) m_freeze = wdata[31];
    end
    m_in_ack = exp_ack;
    @(negedge clk);
    check("ack", {31'd0, sl_ack}, {31'd0, exp_ack});
    check("dbus", sl_dbus, exp_d);
    check("frozen", {31'd0, frozen}, {31'd0, m_freeze});
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    sel = 1; rnw = 1; abus = a; be = 4'b1111;
    step();
    sel = 0;
    check("rd_ack", {31'd0, sl_ack}, 32'd1);
    d = sl_dbus;
    step();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v, input logic [0:3] b);
    sel = 1; rnw = 0; abus = a; wdata = v; be = b;
    step();
    sel = 0;
    check("wr_ack", {31'd0, sl_ack}, 32'd1);
    step();
  endtask

  task automatic capture(input logic [31:0] v);
    valid = 1; din = v;
    step();
    valid = 0;
  endtask

  initial begin
    logic [31:0] d;
    int acks;
    @(negedge clk);
    step(); step();
    rst_n = 1;
    step();

    // Reset state
    bus_read(BASE + 32'h0, d); check("reset_data", d, 32'h0);
    bus_read(BASE + 32'h4, d); check("reset_status", d, 32'h0);
    check("tied_outputs", {29'd0, sl_err, sl_retry, sl_tout}, 32'd0);

    // Single capture, read back, fresh clears
    capture(32'hDEADBEEF);
    bus_read(BASE + 32'h4, d); check("fresh_set", d, 32'h00000001);
    bus_read(BASE + 32'h0, d); check("data_word", d, 32'hDEADBEEF);
    bus_read(BASE + 32'h4, d); check("fresh_clr", d, 32'h00000000);

    // Overruns and count clear
    capture(32'h1); capture(32'h2); capture(32'h3);
    bus_read(BASE + 32'h4, d); check("overrun2", d, 32'h00020001);
    bus_write(BASE + 32'h4, 32'h0, 4'b1111);
    bus_read(BASE + 32'h4, d); check("ovr_cleared", d, 32'h00000001);

    // Freeze
    bus_write(BASE + 32'h8, 32'h1, 4'b0001);
    check("frozen_on", {31'd0, frozen}, 32'd1);
    capture(32'h12345678);
    bus_read(BASE + 32'h4, d); check("frozen_status", d, 32'h00000001);
    bus_read(BASE + 32'h0, d); check("frozen_data", d, 32'h00000003);
    bus_write(BASE + 32'h8, 32'h0, 4'b1110);
    check("freeze_be_gate", {31'd0, frozen}, 32'd1);
    bus_read(BASE + 32'h8, d); check("ctrl_read", d, 32'h00000001);
    bus_write(BASE + 32'h8, 32'h0, 4'b0001);
    check("frozen_off", {31'd0, frozen}, 32'd0);

    // Capture coincident with DATA read decode
    capture(32'h11111111);
    valid = 1; din = 32'hA5A5A5A5;
    sel = 1; rnw = 1; abus = BASE; be = 4'b1111;
    step();
    sel = 0; valid = 0;
    check("coinc_ack", {31'd0, sl_ack}, 32'd1);
    check("coinc_old_word", sl_dbus, 32'h11111111);
    step();
    bus_read(BASE + 32'h4, d); check("coinc_status", d, 32'h00000001);
    bus_read(BASE + 32'h0, d); check("coinc_new_word", d, 32'hA5A5A5A5);

    // Other offsets and DATA write are inert
    bus_write(BASE + 32'h0, 32'hFFFFFFFF, 4'b1111);
    bus_read(BASE + 32'h0, d); check("data_ro", d, 32'hA5A5A5A5);
    bus_read(BASE + 32'hFC, d); check("unmapped_rd", d, 32'h0);

    // Reset during the ACK cycle
    capture(32'h55AA55AA);
    sel = 1; rnw = 1; abus = BASE; be = 4'b1111;
    step();
    sel = 0;
    check("pre_reset_ack", {31'd0, sl_ack}, 32'd1);
    rst_n = 0;
    step();
    check("reset_kills_ack", {31'd0, sl_ack}, 32'd0);
    rst_n = 1;
    step(); step();
    bus_read(BASE + 32'h0, d); check("post_reset_data", d, 32'h0);
    bus_read(BASE + 32'h4, d); check("post_reset_status", d, 32'h0);

    // Outside the window
    acks = 0;
    sel = 1; rnw = 1; abus = 32'h01028000;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sl_ack) acks++;
    end
    sel = 0;
    check("outside_no_ack", acks, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 5))
        0: abus = BASE + 32'h0;
        1: abus = BASE + 32'h4;
        2: abus = BASE + 32'h8;
        3: abus = BASE + ($urandom_range(3, 63) << 2);
        4: abus = HIGH - 32'h3;
        default: abus = ($urandom_range(0, 1) == 1) ? HIGH + 32'h4 : BASE - 32'h4;
      endcase
      sel   = ($urandom_range(0, 1) == 1);
      rnw   = ($urandom_range(0, 1) == 1);
      be    = 4'($urandom);
      wdata = $urandom;
      valid = ($urandom_range(0, 2) == 0);
      din   = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    sel = 0; valid = 0; rst_n = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
OPB slave that carries user-logic data to software, the reverse direction of the ppc2simulink control registers. It captures a 32-bit user word on a qualifier strobe and flags fresh data. It counts overruns, where a new capture lands before software has read the previous one. Software can freeze capture, for example to read snap/vacc status words coherently. Single clock domain: user logic runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h01029000, first byte address of the 256-byte window
C_HIGHADDR, 32'h010290FF, last byte address of the window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
C_FAMILY, "virtex6", target family (informational)

Ports:
OPB_Clk  in  1  sole clock, rising edge
OPB_Rst  in  1  reset; synchronous, active-low
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; all zero unless Sl_xferAck=1
Sl_xferAck  out  1  one-cycle transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_in  in  [31:0]  word to capture
user_valid  in  1  capture strobe
user_frozen  out  1  mirrors CTRL.freeze

Behaviour:
- Register map. In the list below, bit 0 is the LSB, equal to DBus[31].
- Offset 0x00, DATA (RO): last captured word. A read clears fresh.
- Offset 0x04, STATUS: bit0 = fresh; bits[31:16] = overrun count, 16-bit, saturating at 0xFFFF. Any write with BE!=0 clears the count.
- Offset 0x08, CTRL (RW): bit0 = freeze. The write takes effect only when BE[3]=1. Other bits read 0.
- Other offsets in the window: acked; read returns 0; write ignored. Writes to DATA are acked and ignored.
- Address hit: C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Offset = OPB_ABus[24:29] (word index).
- Bus FSM, IDLE -> ACK -> IDLE:
  - IDLE: if OPB_select=1 and the address hits, register read data or perform the write, then go to ACK.
  - ACK: Sl_xferAck=1 and Sl_DBus valid for exactly one cycle; OPB_select is not sampled; return to IDLE.
  - Latency: select sampled at edge N gives xferAck high in cycle N+1. Back-to-back transfers therefore ack every 2nd cycle at best.
- Read data is the register value sampled at the IDLE->ACK edge.
- The fresh-clear side effect of a DATA read commits at the same edge.
- Capture, evaluated every cycle: if user_valid=1 and freeze=0, then DATA<=user_data_in and fresh<=1.
- Overrun increments when a capture occurs while fresh=1 and no DATA read is clearing fresh in the same cycle.
- Capture and DATA read in the same cycle: the read returns the old word; fresh ends at 1 (set wins); no overrun.
- Capture and STATUS count-clear in the same cycle: the clear wins; count=0.
- user_valid while freeze=1: ignored; no overrun.
- Reset (OPB_Rst=0 at an edge): DATA=0, fresh=0, overrun=0, freeze=0, FSM=IDLE, Sl_xferAck=0, Sl_DBus=0, user_frozen=0.
  - Reset mid-transfer (in ACK) kills the ack; no late ack is issued after reset.
- Select not hitting the window: no response; all Sl_* outputs stay 0.

Decomposition:
- Shared package opb_snap_pkg holds:
  - offset constants OFF_DATA=0, OFF_STATUS=1, OFF_CTRL=2 (word index)
  - FSM enum {IDLE, ACK}
  - OVR_W=16
- One natural sub-module, snap_capture. It owns DATA, fresh, overrun and freeze, plus set/clear arbitration. Its inputs are capture, rd_data_clr, ovr_clr and freeze_wr/freeze_val.
- The top level holds the OPB decode and the FSM.

Test Plan:
1. Reset, then read 0x00 and 0x04 -> xferAck exactly one cycle after select, data 0x00000000 both times; Sl_DBus=0 outside ack cycles.
2. user_data_in=0xDEADBEEF with a 1-cycle user_valid, then read 0x04 -> 0x00000001; read 0x00 -> 0xDEADBEEF; read 0x04 -> 0x00000000.
3. Three captures without a read -> STATUS=0x00020001. Write 0x04 with BE=4'b1111 -> STATUS=0x00000001.
4. Write 0x08 data 0x00000001 BE=4'b0001 -> user_frozen=1. Then capture 0x12345678 -> DATA unchanged and overrun unchanged. Write BE=4'b1110 -> freeze stays 1.
5. Capture 0xA5A5A5A5 in the same cycle as the DATA read decode -> read returns the previous word, fresh=1, overrun unchanged.
6. Reset asserted during the ACK cycle -> no xferAck, all registers 0. Select to address 0x01028000 (outside the window) -> no ack for 10 cycles.
